instr_fetch_unit: RTL and testbench

//  Upstream neighbour of the instruction controller (decoder). Holds the PC and issues in-order word reads to instruction memory.

---
 rtl/instr_fetch_unit.sv | 205 ++++++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues in-order word reads to
// instruction memory, buffers returned words in a prefetch FIFO and hands
// them to the decoder over a valid/ready handshake. A redirect flushes all
// buffered words and discards responses to requests already in flight.
module instr_fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_fetch_en,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic        o_in32_valid,
  output logic [31:0] o_in32,
  output logic [31:0] o_in32_pc,
  input  logic        i_in32_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_LIMIT = (CW+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN
  } state_t;

  state_t r_state;
  state_t w_stateNext;

  logic [31:0]   r_pc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_drop;
  logic [CW-1:0] r_count;
  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [31:0]   r_fifoData [DEPTH];
  logic [31:0]   r_fifoPc   [DEPTH];
  logic [31:0]   r_pcq      [DEPTH];
  logic [AW-1:0] r_pcqWr;
  logic [AW-1:0] r_pcqRd;

  logic          w_grant;
  logic          w_rvalid;
  logic          w_push;
  logic          w_pop;
  logic          w_dropDec;
  logic          w_credit;
  logic [CW:0]   w_inUse;
  logic [CW-1:0] w_dropOnRedirect;
  logic [CW-1:0] w_dropAfter;
  logic [31:0]   w_redirectAligned;
  logic [31:0]   w_reqPc;

  // A response that arrives with nothing outstanding is a protocol error and
  // is ignored entirely, so every response-side action is gated by w_rvalid.
  assign w_rvalid          = i_imem_rvalid & (r_outstanding != '0);
  assign w_grant           = o_imem_req & i_imem_gnt;
  assign w_push            = w_rvalid & (r_drop == '0) & ~i_redirect_valid;
  assign w_pop             = o_in32_valid & i_in32_ready & ~i_redirect_valid;
  assign w_dropDec         = w_rvalid & (r_drop != '0) & ~i_redirect_valid;
  assign w_inUse           = {1'b0, r_count} + {1'b0, r_outstanding};
  assign w_credit          = (w_inUse < DEPTH_LIMIT);
  assign w_redirectAligned = i_redirect_pc & ~32'h3;
  assign w_reqPc           = r_pcq[r_pcqRd];

  // No grant can coincide with a redirect, so only a concurrent response
  // reduces the number of stale words still to be discarded.
  assign w_dropOnRedirect  = r_outstanding - CW'(w_rvalid);

  assign o_imem_req   = (r_state == ST_FETCH) & ~i_redirect_valid & w_credit;
  assign o_imem_addr  = r_pc;
  assign o_in32_valid = (r_count != '0);
  assign o_in32       = r_fifoData[r_rdPtr];
  assign o_in32_pc    = r_fifoPc[r_rdPtr];

  // Drop counter value for the next cycle, shared by the FSM and the register.
  always_comb begin
    w_dropAfter = r_drop;
    if (i_redirect_valid) begin
      w_dropAfter = w_dropOnRedirect;
    end else if (w_dropDec) begin
      w_dropAfter = r_drop - CW'(1);
    end
  end

  // Next-state logic: DRAIN holds off new requests until every stale response is gone.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_fetch_en) w_stateNext = ST_FETCH;
      end
      ST_FETCH: begin
        if (i_redirect_valid && (w_dropAfter != '0)) begin
          w_stateNext = ST_DRAIN;
        end else if (!i_fetch_en) begin
          w_stateNext = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (w_dropAfter == '0) begin
          w_stateNext = i_fetch_en ? ST_FETCH : ST_IDLE;
        end
      end
      default: w_stateNext = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_stateNext;
  end

  // PC: a redirect overrides any advance; otherwise step on each grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (i_redirect_valid) begin
      r_pc <= w_redirectAligned;
    end else if (w_grant) begin
      r_pc <= r_pc + PC_STEP;
    end
  end

  // Outstanding-request counter keeps counting straight through redirects.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_outstanding <= '0;
    end else begin
      case ({w_grant, w_rvalid})
        2'b10:   r_outstanding <= r_outstanding + CW'(1);
        2'b01:   r_outstanding <= r_outstanding - CW'(1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  // Number of stale responses still to be discarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_drop <= '0;
    else     r_drop <= w_dropAfter;
  end

  // In-order queue of requested PCs, so each response can be tagged with its address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pcqWr <= '0;
      r_pcqRd <= '0;
      for (int i = 0; i < DEPTH; i++) r_pcq[i] <= '0;
    end else if (i_redirect_valid) begin
      r_pcqWr <= '0;
      r_pcqRd <= '0;
    end else begin
      if (w_grant) begin
        r_pcq[r_pcqWr] <= r_pc;
        r_pcqWr        <= r_pcqWr + AW'(1);
      end
      if (w_push) begin
        r_pcqRd <= r_pcqRd + AW'(1);
      end
    end
  end

  // Prefetch FIFO; the credit rule on requests guarantees it never overflows.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_fifoData[i] <= '0;
        r_fifoPc[i]   <= '0;
      end
    end else if (i_redirect_valid) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_fifoData[r_wrPtr] <= i_imem_rdata;
        r_fifoPc[r_wrPtr]   <= w_reqPc;
        r_wrPtr             <= r_wrPtr + AW'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with an in-order, fixed-latency
// instruction memory model. A second instance built with a high RESET_PC
// exercises the 32-bit PC wrap.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetchEn;
  logic        redirectValid;
  logic [31:0] redirectPc;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemGnt;
  logic        imemRvalid;
  logic [31:0] imemRdata;
  logic        in32Valid;
  logic [31:0] in32;
  logic [31:0] in32Pc;
  logic        in32Ready;

  logic        fetchEn2;
  logic        imemReq2;
  logic [31:0] imemAddr2;
  logic        imemRvalid2;
  logic [31:0] imemRdata2;
  logic        in32Valid2;
  logic [31:0] in32_2;
  logic [31:0] in32Pc2;
  logic        tieOne  = 1'b1;
  logic        tieZero = 1'b0;
  logic [31:0] tieZero32 = 32'h0;

  int          testsRun  = 0;
  int          failCount = 0;
  int          cyc;
  int          memLat;
  logic [31:0] memAddrQ [$];
  int          memDueQ  [$];
  logic        g2Pend;
  logic [31:0] g2Addr;
  logic [31:0] expPc;
  logic [31:0] expPc2;
  int          delivered;
  int          delivered2;
  int          firstDeliv;
  logic [31:0] popAddr;
  int          popDue;

  instr_fetch_unit #(.DEPTH(4), .RESET_PC(32'h0), .PC_STEP(32'd4)) u_dut (
    .clk              (clk),
    .rst              (rst),
    .i_fetch_en       (fetchEn),
    .i_redirect_valid (redirectValid),
    .i_redirect_pc    (redirectPc),
    .o_imem_req       (imemReq),
    .o_imem_addr      (imemAddr),
    .i_imem_gnt       (imemGnt),
    .i_imem_rvalid    (imemRvalid),
    .i_imem_rdata     (imemRdata),
    .o_in32_valid     (in32Valid),
    .o_in32           (in32),
    .o_in32_pc        (in32Pc),
    .i_in32_ready     (in32Ready)
  );

  instr_fetch_unit #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8), .PC_STEP(32'd4)) u_dutWrap (
    .clk              (clk),
    .rst              (rst),
    .i_fetch_en       (fetchEn2),
    .i_redirect_valid (tieZero),
    .i_redirect_pc    (tieZero32),
    .o_imem_req       (imemReq2),
    .o_imem_addr      (imemAddr2),
    .i_imem_gnt       (tieOne),
    .i_imem_rvalid    (imemRvalid2),
    .i_imem_rdata     (imemRdata2),
    .o_in32_valid     (in32Valid2),
    .o_in32           (in32_2),
    .o_in32_pc        (in32Pc2),
    .i_in32_ready     (tieOne)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1234_0000;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    testsRun++;
    assert (obs === expv) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Runs n clock cycles: drives memory responses, records grants and
  // checks every word the decoder accepts against the expected PC stream.
  task automatic applyStimulus(input int n);
    for (int k = 0; k < n; k++) begin
      if (memAddrQ.size() > 0 && memDueQ[0] <= cyc) begin
        imemRvalid = 1'b1;
        imemRdata  = memWord(memAddrQ[0]);
      end else begin
        imemRvalid = 1'b0;
        imemRdata  = 32'h0;
      end
      imemRvalid2 = g2Pend;
      imemRdata2  = g2Pend ? memWord(g2Addr) : 32'h0;
      @(negedge clk);
      if (imemReq && imemGnt) begin
        memAddrQ.push_back(imemAddr);
        memDueQ.push_back(cyc + memLat);
      end
      if (imemRvalid) begin
        popAddr = memAddrQ.pop_front();
        popDue  = memDueQ.pop_front();
      end
      g2Pend = imemReq2;
      g2Addr = imemAddr2;
      if (in32Valid && in32Ready && !redirectValid) begin
        checkOutput("in32_pc", in32Pc, expPc);
        checkOutput("in32", in32, memWord(expPc));
        expPc = expPc + 32'd4;
        delivered++;
        if (firstDeliv < 0) firstDeliv = cyc;
      end
      if (in32Valid2) begin
        checkOutput("wrap_in32_pc", in32Pc2, expPc2);
        checkOutput("wrap_in32", in32_2, memWord(expPc2));
        expPc2 = expPc2 + 32'd4;
        delivered2++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  // Resets both units together with the memory model; returns at posedge+1
  // with reset released and the cycle counter at 0.
  task automatic applyReset();
    rst           = 1'b1;
    fetchEn       = 1'b0;
    fetchEn2      = 1'b0;
    redirectValid = 1'b0;
    redirectPc    = 32'h0;
    imemGnt       = 1'b1;
    imemRvalid    = 1'b0;
    imemRdata     = 32'h0;
    imemRvalid2   = 1'b0;
    imemRdata2    = 32'h0;
    in32Ready     = 1'b0;
    memAddrQ.delete();
    memDueQ.delete();
    g2Pend        = 1'b0;
    g2Addr        = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    rst        = 1'b0;
    cyc        = 0;
    delivered  = 0;
    delivered2 = 0;
    firstDeliv = -1;
  endtask

  initial begin
    memLat = 1;
    expPc  = 32'h0;
    expPc2 = 32'hFFFF_FFF8;
    applyReset();
    rst = 1'b1;
    #1;
    checkOutput("reset_req", {31'h0, imemReq}, 32'h0);
    checkOutput("reset_addr", imemAddr, 32'h0);
    checkOutput("reset_valid", {31'h0, in32Valid}, 32'h0);
    checkOutput("reset_in32", in32, 32'h0);
    checkOutput("reset_in32_pc", in32Pc, 32'h0);
    checkOutput("reset_wrap_addr", imemAddr2, 32'hFFFF_FFF8);
    applyReset();

    // Streaming: one word per cycle once the pipeline is primed.
    memLat    = 1;
    expPc     = 32'h0;
    fetchEn   = 1'b1;
    in32Ready = 1'b1;
    applyStimulus(20);
    checkOutput("stream_first_cycle", firstDeliv, 3);
    checkOutput("stream_count", delivered, 17);

    // Decoder stall: FIFO fills to DEPTH and requests stop.
    in32Ready = 1'b0;
    applyStimulus(10);
    checkOutput("stall_valid", {31'h0, in32Valid}, 32'h1);
    checkOutput("stall_req", {31'h0, imemReq}, 32'h0);
    checkOutput("stall_head_pc", in32Pc, expPc);
    in32Ready = 1'b1;
    applyStimulus(4);
    checkOutput("stall_release_count", delivered, 21);
    applyStimulus(4);

    // Redirect with three requests in flight: all three responses are stale.
    applyReset();
    memLat    = 4;
    expPc     = 32'h0;
    fetchEn   = 1'b1;
    in32Ready = 1'b1;
    applyStimulus(4);
    checkOutput("redir_pre_req", {31'h0, imemReq}, 32'h1);
    checkOutput("redir_pre_count", delivered, 0);
    redirectValid = 1'b1;
    redirectPc    = 32'h100;
    expPc         = 32'h100;
    #1;
    checkOutput("redir_req_suppressed", {31'h0, imemReq}, 32'h0);
    applyStimulus(1);
    redirectValid = 1'b0;
    redirectPc    = 32'h0;
    checkOutput("drain_no_req", {31'h0, imemReq}, 32'h0);
    applyStimulus(16);
    checkOutput("redir_some_delivered", {31'h0, 1'(delivered >= 2)}, 32'h1);

    // PC wrap on the second instance.
    applyReset();
    fetchEn2 = 1'b1;
    expPc2   = 32'hFFFF_FFF8;
    applyStimulus(8);
    checkOutput("wrap_count", delivered2, 5);
    fetchEn2 = 1'b0;

    // Redirect colliding with a response and a decoder handshake.
    applyReset();
    memLat    = 1;
    expPc     = 32'h0;
    fetchEn   = 1'b1;
    in32Ready = 1'b1;
    applyStimulus(6);
    checkOutput("collide_pre_count", delivered, 3);
    checkOutput("collide_valid", {31'h0, in32Valid}, 32'h1);
    checkOutput("collide_head_pc", in32Pc, 32'hC);
    redirectValid = 1'b1;
    redirectPc    = 32'h203;
    expPc         = 32'h200;
    applyStimulus(1);
    redirectValid = 1'b0;
    redirectPc    = 32'h0;
    applyStimulus(10);
    checkOutput("collide_count", delivered, 11);

    // Asynchronous reset with words buffered and requests in flight.
    applyReset();
    memLat    = 6;
    expPc     = 32'h0;
    fetchEn   = 1'b1;
    in32Ready = 1'b0;
    applyStimulus(9);
    checkOutput("busy_valid", {31'h0, in32Valid}, 32'h1);
    checkOutput("busy_req", {31'h0, imemReq}, 32'h0);
    checkOutput("busy_head_pc", in32Pc, 32'h0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_req", {31'h0, imemReq}, 32'h0);
    checkOutput("async_addr", imemAddr, 32'h0);
    checkOutput("async_valid", {31'h0, in32Valid}, 32'h0);
    checkOutput("async_in32", in32, 32'h0);
    checkOutput("async_in32_pc", in32Pc, 32'h0);
    applyReset();
    memLat    = 1;
    expPc     = 32'h0;
    fetchEn   = 1'b1;
    in32Ready = 1'b1;
    applyStimulus(8);
    checkOutput("restart_count", delivered, 5);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
